// File: rtl/evu_multi_chan.sv
// evu_multi_chan: per-channel event select, privilege filter and prescaler feeding
// a tagged packet FIFO for the SPU, with a config/status register window.
module evu_multi_chan #(
    parameter int NUM_EVENTS     = 16,
    parameter int NUM_CHANNELS   = 4,
    parameter int PRESCALE_WIDTH = 16,
    parameter int ASID_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int CFG_ADDR_WIDTH = 6,
    localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_EVENTS-1:0]     events_i,
    input  logic [1:0]                priv_lvl_i,
    input  logic [ASID_WIDTH-1:0]     asid_i,
    input  logic                      cfg_we_i,
    input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr_i,
    input  logic [31:0]               cfg_wdata_i,
    output logic [31:0]               cfg_rdata_o,
    output logic [NUM_CHANNELS-1:0]   evt_line_o,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic [CW-1:0]             evt_chan_o,
    output logic [1:0]                evt_priv_o,
    output logic [ASID_WIDTH-1:0]     evt_asid_o,
    output logic                      overflow_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CFG_ADDR_WIDTH-1:0] STAT_ADDR = CFG_ADDR_WIDTH'(2 * NUM_CHANNELS);

    typedef struct packed {
        logic [CW-1:0]         chan;
        logic [1:0]            priv;
        logic [ASID_WIDTH-1:0] asid;
    } pkt_t;

    logic [NUM_CHANNELS-1:0] pend, fire, drop, grant;
    logic [1:0]              pend_priv [NUM_CHANNELS];
    logic [ASID_WIDTH-1:0]   pend_asid [NUM_CHANNELS];
    logic [31:0]             ctrl_rd   [NUM_CHANNELS];
    logic [31:0]             div_rd    [NUM_CHANNELS];
    pkt_t                    mem       [FIFO_DEPTH];
    pkt_t                    push_pkt;
    logic [PW:0]             wptr, rptr, count;
    logic                    full, push, pop, ovf, unused_wdata;

    assign unused_wdata = ^cfg_wdata_i;
    assign count        = wptr - rptr;
    assign full         = count == (PW + 1)'(FIFO_DEPTH);
    assign evt_valid_o  = count != '0;
    assign pop          = evt_valid_o & evt_ready_i;
    assign push         = |grant;
    assign overflow_o   = ovf;
    assign {evt_chan_o, evt_priv_o, evt_asid_o} = mem[rptr[PW-1:0]];

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic                      en_r, pend_r, line_r, q, pok, hit, ctrl_hit, div_hit;
        logic [2:0]                mask_r;
        logic [7:0]                sel_r;
        logic [PRESCALE_WIDTH-1:0] div_r, cnt_r;
        logic [1:0]                priv_r;
        logic [ASID_WIDTH-1:0]     asid_r;
        assign ctrl_hit = cfg_we_i && cfg_addr_i == CFG_ADDR_WIDTH'(2 * c);
        assign div_hit  = cfg_we_i && cfg_addr_i == CFG_ADDR_WIDTH'(2 * c + 1);
        // Shifting past the top yields zero, so out-of-range selects never fire.
        assign hit = ((events_i >> sel_r) & NUM_EVENTS'(1)) != '0;
        assign pok = priv_lvl_i == 2'd0 ? mask_r[0] :
                     priv_lvl_i == 2'd1 ? mask_r[1] :
                     priv_lvl_i == 2'd3 ? mask_r[2] : 1'b0;
        assign q       = en_r & hit & pok;
        assign fire[c] = q & (div_r <= PRESCALE_WIDTH'(1) || cnt_r == div_r - PRESCALE_WIDTH'(1));
        assign drop[c] = fire[c] & pend_r & ~grant[c];
        assign pend[c]      = pend_r;
        assign pend_priv[c] = priv_r;
        assign pend_asid[c] = asid_r;
        assign evt_line_o[c] = line_r;
        assign ctrl_rd[c] = {16'b0, sel_r, 4'b0, mask_r, en_r};
        assign div_rd[c]  = 32'(div_r);
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                {en_r, mask_r, sel_r, div_r, cnt_r} <= '0;
                {pend_r, line_r, priv_r, asid_r}    <= '0;
            end else begin
                if (ctrl_hit) {sel_r, mask_r, en_r} <= {cfg_wdata_i[15:8], cfg_wdata_i[3:0]};
                if (div_hit) div_r <= cfg_wdata_i[PRESCALE_WIDTH-1:0];
                if (ctrl_hit || div_hit) cnt_r <= '0;
                else if (q && div_r > PRESCALE_WIDTH'(1)) cnt_r <= fire[c] ? '0 : cnt_r + PRESCALE_WIDTH'(1);
                line_r <= fire[c];
                if (fire[c] && !drop[c]) begin
                    pend_r <= 1'b1;
                    priv_r <= priv_lvl_i;
                    asid_r <= asid_i;
                end else if (grant[c]) begin
                    pend_r <= 1'b0;
                end
            end
        end
    end

    // A full FIFO still accepts a push when its head leaves the same cycle.
    always_comb begin
        grant    = '0;
        push_pkt = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (pend[i] && grant == '0 && (!full || pop)) begin
                grant[i] = 1'b1;
                push_pkt = {CW'(i), pend_priv[i], pend_asid[i]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr[PW-1:0]] <= push_pkt;
                wptr <= wptr + (PW + 1)'(1);
            end
            if (pop) rptr <= rptr + (PW + 1)'(1);
            if (|drop) ovf <= 1'b1;
            else if (cfg_we_i && cfg_addr_i == STAT_ADDR && cfg_wdata_i[0]) ovf <= 1'b0;
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (cfg_addr_i == CFG_ADDR_WIDTH'(2 * i)) cfg_rdata_o = ctrl_rd[i];
            if (cfg_addr_i == CFG_ADDR_WIDTH'(2 * i + 1)) cfg_rdata_o = div_rd[i];
        end
        if (cfg_addr_i == STAT_ADDR) cfg_rdata_o = {16'b0, 8'(count), 7'b0, ovf};
    end
endmodule

// File: tb/tb_evu_multi_chan.sv
// tb_evu_multi_chan: directed stimulus checked every cycle against a queue-based
// behavioural model of the event unit, plus hand-computed literal expectations.
module tb_evu_multi_chan;
    logic        clk = 0, rst_n = 0;
    logic [15:0] events = '0, asid = '0;
    logic [1:0]  priv = '0;
    logic        cfg_we = 0, ready = 0;
    logic [5:0]  cfg_addr = 6'd8;
    logic [31:0] cfg_wdata = '0, rdata;
    logic [3:0]  line;
    logic        valid, ovf;
    logic [1:0]  chan, epriv;
    logic [15:0] easid;

    int checks = 0, errors = 0, n1 = 0;
    int got_chan[$], got_priv[$];

    evu_multi_chan dut (
        .clk_i(clk), .rst_ni(rst_n), .events_i(events), .priv_lvl_i(priv), .asid_i(asid),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_rdata_o(rdata),
        .evt_line_o(line), .evt_valid_o(valid), .evt_ready_i(ready), .evt_chan_o(chan),
        .evt_priv_o(epriv), .evt_asid_o(easid), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { int chan; int priv; int asid; } pkt_t;
    pkt_t m_q[$];
    bit       m_en[4], m_pend[4], m_line[4], m_ovf;
    bit [3:1] m_mask[4];
    int       m_sel[4], m_div[4], m_cnt[4], m_ppriv[4], m_pasid[4];

    function automatic logic [31:0] mread(input int a);
        if (a < 8 && a % 2 == 0) return {16'b0, 8'(m_sel[a/2]), 4'b0, m_mask[a/2], m_en[a/2]};
        if (a < 8) return 32'(m_div[a/2]);
        if (a == 8) return {16'b0, 8'(m_q.size()), 7'b0, m_ovf};
        return '0;
    endfunction

    task automatic mreset();
        m_q.delete();
        m_ovf = 0;
        for (int c = 0; c < 4; c++) begin
            m_en[c] = 0; m_pend[c] = 0; m_line[c] = 0; m_mask[c] = 0;
            m_sel[c] = 0; m_div[c] = 0; m_cnt[c] = 0; m_ppriv[c] = 0; m_pasid[c] = 0;
        end
    endtask

    task automatic mstep();
        bit   f[4], qual, okp, pop, drop;
        int   g = -1;
        for (int c = 0; c < 4; c++) begin
            okp  = (priv == 0 && m_mask[c][1]) || (priv == 1 && m_mask[c][2]) || (priv == 3 && m_mask[c][3]);
            qual = m_en[c] && m_sel[c] < 16 && okp && events[m_sel[c]];
            f[c] = 0;
            if (m_div[c] <= 1) f[c] = qual;
            else if (qual) begin
                m_cnt[c] = (m_cnt[c] + 1) % m_div[c];
                f[c] = m_cnt[c] == 0;
            end
        end
        pop = m_q.size() > 0 && ready;
        if (m_q.size() - int'(pop) < 4)
            for (int c = 3; c >= 0; c--) if (m_pend[c]) g = c;
        if (pop) void'(m_q.pop_front());
        if (g >= 0) m_q.push_back('{g, m_ppriv[g], m_pasid[g]});
        drop = 0;
        for (int c = 0; c < 4; c++) begin
            if (f[c] && m_pend[c] && c != g) drop = 1;
            else if (f[c]) begin m_pend[c] = 1; m_ppriv[c] = priv; m_pasid[c] = asid; end
            else if (c == g) m_pend[c] = 0;
            m_line[c] = f[c];
        end
        if (drop) m_ovf = 1;
        else if (cfg_we && cfg_addr == 8 && cfg_wdata[0]) m_ovf = 0;
        if (cfg_we && cfg_addr < 8) begin
            if (cfg_addr % 2 == 0) begin
                m_en[cfg_addr/2] = cfg_wdata[0];
                m_mask[cfg_addr/2] = cfg_wdata[3:1];
                m_sel[cfg_addr/2] = cfg_wdata[15:8];
            end else m_div[cfg_addr/2] = cfg_wdata[15:0];
            m_cnt[cfg_addr/2] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset();
        else begin
            mstep();
            #1;
            chk("valid", valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("chan", chan, m_q[0].chan);
                chk("priv", epriv, m_q[0].priv);
                chk("asid", easid, m_q[0].asid);
            end
            chk("overflow", ovf, m_ovf);
            chk("line", line, {m_line[3], m_line[2], m_line[1], m_line[0]});
            chk("rdata", rdata, mread(cfg_addr));
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            got_chan.push_back(chan);
            got_priv.push_back(epriv);
        end
        if (line[1]) n1++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cfg_we = 1; cfg_addr = 6'(a); cfg_wdata = d;
        @(negedge clk);
        cfg_we = 0; cfg_addr = 6'd8; cfg_wdata = '0;
    endtask

    task automatic pulse(input int e);
        events = '0;
        events[e] = 1'b1;
        @(negedge clk);
        events = '0;
    endtask

    initial begin
        tick(2);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_line", line, 0);
        chk("rst_status", rdata, 0);
        rst_n = 1;
        tick(1);

        // 1: single fire, latency to line and to packet
        wr(0, 32'h0309);
        priv = 3; asid = 16'h1234; ready = 1;
        events = 16'h0008;
        @(negedge clk);
        events = '0;
        chk("t1_line", line, 4'b0001);
        chk("t1_early_valid", valid, 0);
        @(negedge clk);
        chk("t1_valid", valid, 1);
        chk("t1_chan", chan, 0);
        chk("t1_priv", epriv, 3);
        chk("t1_asid", easid, 16'h1234);
        tick(3);

        // 2: divide by 4 on channel 1
        wr(0, 0);
        wr(2, 32'h0509);
        wr(3, 4);
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            asid = 16'(16'h100 + i);
            pulse(5);
            tick(1);
        end
        tick(2);
        chk("t2_fires", n1, 2);
        pulse(5); tick(2);
        chk("t2_cnt3", n1, 2);
        pulse(5); tick(2);
        chk("t2_cnt_wrap", n1, 3);
        tick(3);

        // 3: U-only privilege mask
        wr(2, 0);
        wr(0, 32'h0303);
        got_chan.delete(); got_priv.delete();
        priv = 3; pulse(3); tick(2);
        priv = 0; pulse(3); tick(4);
        chk("t3_npkt", got_priv.size(), 1);
        if (got_priv.size() == 1) chk("t3_priv", got_priv[0], 0);

        // 4: four channels firing together
        wr(3, 0);
        for (int c = 0; c < 4; c++) wr(2 * c, 32'h0309);
        priv = 3; asid = 16'hBEEF;
        got_chan.delete(); got_priv.delete();
        pulse(3);
        tick(8);
        chk("t4_npkt", got_chan.size(), 4);
        if (got_chan.size() == 4)
            for (int i = 0; i < 4; i++) chk("t4_order", got_chan[i], i);
        chk("t4_ovf", ovf, 0);

        // 5: backpressure, pend then drop
        for (int c = 1; c < 4; c++) wr(2 * c, 0);
        ready = 0;
        for (int i = 0; i < 6; i++) begin
            asid = 16'(16'hA0 + i);
            pulse(3);
            tick(1);
        end
        tick(2);
        chk("t5_status", rdata, 32'h0000_0401);
        chk("t5_ovf", ovf, 1);
        ready = 1;
        tick(8);
        wr(8, 1);
        chk("t5_ovf_clr", ovf, 0);

        // 6: W1C colliding with a drop, then reset mid-burst
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            pulse(3);
            tick(1);
        end
        events = 16'h0008; cfg_we = 1; cfg_addr = 6'd8; cfg_wdata = 1;
        @(negedge clk);
        events = '0; cfg_we = 0; cfg_wdata = '0;
        chk("t6_set_wins", ovf, 1);
        tick(1);
        ready = 1;
        tick(2);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_status", rdata, 0);
        chk("t6_rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1;
        tick(3);
        chk("t6_post_valid", valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
